mario_sound_cmd: RTL and testbench

Main-CPU-side sound command interface: the sending end of the link the digital sound CPU reads as `I_SND_DATA[7:0]` and `I_SND_CTRL[6:0]`. It converts main-CPU write strobes into three things:
- a held 8-bit command latch;
- a pending-command interrupt request with acknowledge and timeout;
- two stretched trigger pulses on T0/T1, plus four level control bits.

It sits between the main-CPU address decoder and `mario_sound_digital`.

---
 rtl/mario_sound_cmd.sv | 138 +++++++++++++
 tb/tb_mario_sound_cmd.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mario_sound_cmd.sv
// Main-CPU side of the sound link: command latch, pending IRQ with
// ack/timeout, T0/T1 one-shots and four level control bits.
module mario_sound_cmd #(
  parameter int IRQ_TIMEOUT = 4095,
  parameter int PULSE_LEN   = 64
) (
  input  logic       I_CLK_48M,
  input  logic       I_RST,
  input  logic       I_CEN_4M,
  input  logic [7:0] I_CPU_D,
  input  logic [2:0] I_CPU_A,
  input  logic       I_LATCH_WR,
  input  logic       I_CTRL_WR,
  input  logic       I_SND_ACK,
  output logic [7:0] O_SND_DATA,
  output logic [6:0] O_SND_CTRL,
  output logic       O_PENDING
);

  localparam logic [11:0] TMO  = 12'(IRQ_TIMEOUT);
  localparam logic [11:0] PLEN = 12'(PULSE_LEN);

  typedef enum logic {IDLE, PEND} state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_tmo, w_tmo_nxt;
  logic [2:0]  r_stb_q, r_arm;
  logic [2:0]  w_stb, w_ev;
  logic [7:0]  r_data;
  logic [5:0]  r_areg;
  logic [11:0] r_pcnt [2];
  logic [1:0]  r_os;
  logic [1:0]  w_fire;

  // A strobe only counts once it has been seen low since reset
  assign w_stb = {I_SND_ACK, I_CTRL_WR, I_LATCH_WR};
  assign w_ev  = w_stb & ~r_stb_q & r_arm;

  always_ff @(posedge I_CLK_48M or posedge I_RST) begin
    if (I_RST) begin
      r_stb_q <= '0;
      r_arm   <= '0;
    end else begin
      r_stb_q <= w_stb;
      r_arm   <= r_arm | ~w_stb;
    end
  end

  always_ff @(posedge I_CLK_48M or posedge I_RST) begin
    if (I_RST) begin
      r_state <= IDLE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo;
    unique case (r_state)
      IDLE: begin
        if (w_ev[0]) begin
          w_state_nxt = PEND;
          w_tmo_nxt   = TMO;
        end
      end
      PEND: begin
        if (w_ev[0]) begin
          w_tmo_nxt = TMO;
        end else if (w_ev[2]) begin
          w_state_nxt = IDLE;
        end else if (I_CEN_4M) begin
          if (r_tmo <= 12'd1) begin
            w_state_nxt = IDLE;
            w_tmo_nxt   = '0;
          end else begin
            w_tmo_nxt = r_tmo - 12'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK_48M or posedge I_RST) begin
    if (I_RST) begin
      r_data <= '0;
    end else if (w_ev[0]) begin
      r_data <= I_CPU_D;
    end
  end

  // Bits 6/7 of the addressable latch drive nothing and are not kept
  always_ff @(posedge I_CLK_48M or posedge I_RST) begin
    if (I_RST) begin
      r_areg <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_ev[1] && I_CPU_A == 3'(i)) begin
          r_areg[i] <= I_CPU_D[0];
        end
      end
    end
  end

  always_comb begin
    w_fire = '0;
    for (int b = 0; b < 2; b++) begin
      w_fire[b] = w_ev[1] && I_CPU_A == 3'(b) &&
                  I_CPU_D[0] && !r_areg[b];
    end
  end

  always_ff @(posedge I_CLK_48M or posedge I_RST) begin
    if (I_RST) begin
      r_pcnt[0] <= '0;
      r_pcnt[1] <= '0;
      r_os      <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_fire[b]) begin
          r_pcnt[b] <= PLEN;
          r_os[b]   <= 1'b1;
        end else if (I_CEN_4M && r_pcnt[b] != '0) begin
          r_pcnt[b] <= r_pcnt[b] - 12'd1;
          r_os[b]   <= (r_pcnt[b] != 12'd1);
        end
      end
    end
  end

  assign O_SND_DATA = r_data;
  assign O_SND_CTRL = {r_areg[5:2], r_os, (r_state == PEND)};
  assign O_PENDING  = (r_state == PEND);

endmodule

// File: tb/tb_mario_sound_cmd.sv
// Directed and random checks of mario_sound_cmd against a
// tick-counting reference model.
module tb_mario_sound_cmd;

  localparam int TO = 10;
  localparam int PL = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic [7:0] d;
  logic [2:0] addr;
  logic       l, c, a;
  logic [7:0] sdata;
  logic [6:0] sctrl;
  logic       pend;

  int n_tests = 0;
  int n_fail  = 0;

  bit [7:0] m_data;
  bit       m_pend;
  int       m_tmo;
  int       m_rem [2];
  bit [7:0] m_reg;
  bit       m_prev [3];
  bit       m_arm [3];

  mario_sound_cmd #(.IRQ_TIMEOUT(TO), .PULSE_LEN(PL)) dut (
    .I_CLK_48M (clk),
    .I_RST     (rst),
    .I_CEN_4M  (cen),
    .I_CPU_D   (d),
    .I_CPU_A   (addr),
    .I_LATCH_WR(l),
    .I_CTRL_WR (c),
    .I_SND_ACK (a),
    .O_SND_DATA(sdata),
    .O_SND_CTRL(sctrl),
    .O_PENDING (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_data = 0; m_pend = 0; m_tmo = 0; m_reg = 0;
    for (int i = 0; i < 2; i++) m_rem[i] = 0;
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = 0; m_arm[i] = 0;
    end
  endfunction

  function automatic void m_edge();
    bit s [3];
    bit ev [3];
    s[0] = l; s[1] = c; s[2] = a;
    for (int i = 0; i < 3; i++) begin
      ev[i] = s[i] && !m_prev[i] && m_arm[i];
      if (!s[i]) m_arm[i] = 1;
      m_prev[i] = s[i];
    end
    if (ev[0]) begin
      m_data = d; m_pend = 1; m_tmo = TO;
    end else if (m_pend) begin
      if (ev[2]) m_pend = 0;
      else if (cen) begin
        if (m_tmo <= 1) begin m_tmo = 0; m_pend = 0; end
        else m_tmo = m_tmo - 1;
      end
    end
    for (int b = 0; b < 2; b++) begin
      if (ev[1] && int'(addr) == b && d[0] && !m_reg[b]) m_rem[b] = PL;
      else if (cen && m_rem[b] > 0) m_rem[b] = m_rem[b] - 1;
    end
    if (ev[1]) m_reg[addr] = d[0];
  endfunction

  task automatic check_all();
    logic [6:0] e;
    e = {m_reg[5:2], m_rem[1] > 0, m_rem[0] > 0, m_pend};
    chk("data", 32'(sdata), 32'(m_data));
    chk("ctrl", 32'(sctrl), 32'(e));
    chk("pend", 32'(pend), 32'(m_pend));
  endtask

  task automatic step(input bit il, input bit ic, input bit ia,
                      input bit icen, input logic [7:0] id,
                      input logic [2:0] iaddr);
    l = il; c = ic; a = ia; cen = icen; d = id; addr = iaddr;
    @(posedge clk);
    m_edge();
    #1 check_all();
  endtask

  task automatic idle(input int n, input bit icen);
    for (int i = 0; i < n; i++) step(0, 0, 0, icen, 8'h00, 3'd0);
  endtask

  task automatic wr_ctrl(input logic [2:0] ad, input bit v);
    step(0, 1, 0, 0, {7'b0, v}, ad);
    step(0, 0, 0, 0, 8'h00, 3'd0);
  endtask

  task automatic do_reset(input bit hold_l);
    #2;
    l = hold_l; c = 0; a = 0; cen = 0;
    rst = 1'b1;
    #1;
    chk("rst_data", 32'(sdata), 32'h0);
    chk("rst_ctrl", 32'(sctrl), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    m_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 0; d = 0; addr = 0; l = 0; c = 0; a = 0;
    m_reset();
    #12;
    chk("init_data", 32'(sdata), 32'h0);
    chk("init_ctrl", 32'(sctrl), 32'h0);
    rst = 1'b0;
    idle(2, 0);

    step(1, 0, 0, 0, 8'hA5, 3'd0);
    chk("a5_data", 32'(sdata), 32'hA5);
    chk("a5_irq", 32'(sctrl[0]), 32'h1);
    step(0, 0, 0, 0, 8'h00, 3'd0);
    step(0, 0, 1, 0, 8'h00, 3'd0);
    chk("ack_irq", 32'(sctrl[0]), 32'h0);
    chk("ack_data", 32'(sdata), 32'hA5);
    step(0, 0, 0, 0, 8'h00, 3'd0);

    step(1, 0, 0, 0, 8'h3C, 3'd0);
    step(0, 0, 0, 0, 8'h00, 3'd0);
    idle(9, 1);
    chk("tmo_9", 32'(pend), 32'h1);
    idle(1, 1);
    chk("tmo_10", 32'(pend), 32'h0);

    step(1, 0, 0, 0, 8'h3C, 3'd0);
    step(0, 0, 0, 0, 8'h00, 3'd0);
    idle(4, 1);
    step(1, 0, 0, 1, 8'h3D, 3'd0);
    step(0, 0, 0, 0, 8'h00, 3'd0);
    idle(9, 1);
    chk("retmo_14", 32'(pend), 32'h1);
    chk("retmo_data", 32'(sdata), 32'h3D);
    idle(1, 1);
    chk("retmo_15", 32'(pend), 32'h0);

    step(1, 0, 0, 0, 8'h11, 3'd0);
    step(0, 0, 0, 0, 8'h00, 3'd0);
    step(1, 0, 1, 0, 8'h22, 3'd0);
    chk("coll_irq", 32'(pend), 32'h1);
    chk("coll_data", 32'(sdata), 32'h22);
    step(0, 0, 0, 0, 8'h00, 3'd0);

    wr_ctrl(3'd0, 1);
    chk("os_set", 32'(sctrl[1]), 32'h1);
    idle(63, 1);
    chk("os_63", 32'(sctrl[1]), 32'h1);
    idle(1, 1);
    chk("os_64", 32'(sctrl[1]), 32'h0);
    wr_ctrl(3'd0, 1);
    chk("os_norefire", 32'(sctrl[1]), 32'h0);
    wr_ctrl(3'd0, 0);
    wr_ctrl(3'd0, 1);
    idle(30, 1);
    wr_ctrl(3'd0, 0);
    wr_ctrl(3'd0, 1);
    idle(63, 1);
    chk("os_retrig_93", 32'(sctrl[1]), 32'h1);
    idle(1, 1);
    chk("os_retrig_94", 32'(sctrl[1]), 32'h0);

    wr_ctrl(3'd2, 1);
    wr_ctrl(3'd3, 0);
    wr_ctrl(3'd4, 1);
    wr_ctrl(3'd5, 1);
    chk("lvl", 32'(sctrl[6:3]), 32'hD);
    wr_ctrl(3'd7, 1);
    chk("lvl_b7", 32'(sctrl), 32'h68);

    step(1, 0, 0, 0, 8'h77, 3'd0);
    step(0, 0, 0, 0, 8'h00, 3'd0);
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h55, 3'd0);
    chk("held_noev", 32'(pend), 32'h0);
    step(0, 0, 0, 0, 8'h00, 3'd0);
    step(1, 0, 0, 0, 8'h56, 3'd0);
    chk("rearm_ev", 32'(pend), 32'h1);
    chk("rearm_data", 32'(sdata), 32'h56);
    step(0, 0, 0, 0, 8'h00, 3'd0);

    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset($urandom_range(0, 1) == 1);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
           8'($urandom), 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
